// File: rtl/remote_load_resp.sv
`timescale 1ns/1ps
`default_nettype none
// remote_load_resp: buffers remote load responses, decodes load_info and routes each word
// to the integer regfile, FP regfile or icache refill port; also counts outstanding loads.
module remote_load_resp #(
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 5,
  parameter int fifo_els_p       = 2,
  parameter int max_out_loads_p  = 32
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  resp_v_i,
  output logic                                  resp_ready_o,
  input  logic [data_width_p-1:0]               resp_data_i,
  input  logic [reg_addr_width_p-1:0]           resp_reg_id_i,
  input  logic                                  resp_float_wb_i,
  input  logic                                  resp_icache_fetch_i,
  input  logic                                  resp_is_unsigned_i,
  input  logic                                  resp_is_byte_i,
  input  logic                                  resp_is_hex_i,
  input  logic [1:0]                            resp_part_sel_i,
  input  logic                                  load_issue_i,
  output logic                                  int_wb_v_o,
  output logic [reg_addr_width_p-1:0]           int_wb_rd_o,
  output logic [data_width_p-1:0]               int_wb_data_o,
  input  logic                                  int_wb_yumi_i,
  output logic                                  flt_wb_v_o,
  output logic [reg_addr_width_p-1:0]           flt_wb_rd_o,
  output logic [data_width_p-1:0]               flt_wb_data_o,
  input  logic                                  flt_wb_yumi_i,
  output logic                                  icache_wb_v_o,
  output logic [data_width_p-1:0]               icache_wb_data_o,
  output logic [$clog2(max_out_loads_p+1)-1:0]  out_loads_o,
  output logic                                  out_loads_full_o,
  output logic                                  out_loads_empty_o
);

  localparam int ptr_w_lp  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int fcnt_w_lp = $clog2(fifo_els_p + 1);
  localparam int cnt_w_lp  = $clog2(max_out_loads_p + 1);

  typedef struct packed {
    logic [data_width_p-1:0]     data;
    logic [reg_addr_width_p-1:0] rd;
    logic                        float_wb;
    logic                        icache_fetch;
    logic                        is_unsigned;
    logic                        is_byte;
    logic                        is_hex;
    logic [1:0]                  part_sel;
  } entry_t;

  entry_t                mem [fifo_els_p];
  entry_t                head;
  entry_t                in_entry;
  logic [ptr_w_lp-1:0]   wr_ptr;
  logic [ptr_w_lp-1:0]   rd_ptr;
  logic [fcnt_w_lp-1:0]  fifo_cnt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  enq;
  logic                  deq;
  logic                  drop;
  logic [data_width_p-1:0] shifted;
  logic [7:0]            byte_val;
  logic [15:0]           half_val;
  logic [data_width_p-1:0] ext_data;

  function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_entry = '{data: resp_data_i, rd: resp_reg_id_i, float_wb: resp_float_wb_i,
                      icache_fetch: resp_icache_fetch_i, is_unsigned: resp_is_unsigned_i,
                      is_byte: resp_is_byte_i, is_hex: resp_is_hex_i,
                      part_sel: resp_part_sel_i};

  assign fifo_full    = (fifo_cnt == fcnt_w_lp'(fifo_els_p));
  assign fifo_empty   = (fifo_cnt == '0);
  assign resp_ready_o = ~fifo_full;
  assign enq          = resp_v_i & ~fifo_full;
  assign head         = mem[rd_ptr];

  // Priority: icache refill, then FP, then integer; rd=0 integer loads are discarded.
  assign icache_wb_v_o = ~fifo_empty & head.icache_fetch;
  assign flt_wb_v_o    = ~fifo_empty & ~head.icache_fetch & head.float_wb;
  assign int_wb_v_o    = ~fifo_empty & ~head.icache_fetch & ~head.float_wb & (head.rd != '0);
  assign drop          = ~fifo_empty & ~head.icache_fetch & ~head.float_wb & (head.rd == '0);
  assign deq           = icache_wb_v_o | drop | (flt_wb_v_o & flt_wb_yumi_i)
                       | (int_wb_v_o & int_wb_yumi_i);

  assign shifted  = head.data >> {head.part_sel, 3'b000};
  assign byte_val = shifted[7:0];
  assign half_val = head.part_sel[1] ? head.data[31:16] : head.data[15:0];

  always_comb begin
    ext_data = head.data;
    if (head.is_byte)
      ext_data = {{(data_width_p-8){~head.is_unsigned & byte_val[7]}}, byte_val};
    else if (head.is_hex)
      ext_data = {{(data_width_p-16){~head.is_unsigned & half_val[15]}}, half_val};
  end

  assign int_wb_rd_o      = head.rd;
  assign int_wb_data_o    = ext_data;
  assign flt_wb_rd_o      = head.rd;
  assign flt_wb_data_o    = head.data;
  assign icache_wb_data_o = head.data;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (enq) wr_ptr <= bump(wr_ptr);
      if (deq) rd_ptr <= bump(rd_ptr);
      if (enq & ~deq)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (deq & ~enq) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr] <= in_entry;
  end

  // Issue and return in the same cycle cancel; both ends saturate.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      out_loads_o <= '0;
    else if (load_issue_i & ~enq & ~out_loads_full_o)
      out_loads_o <= out_loads_o + 1'b1;
    else if (enq & ~load_issue_i & ~out_loads_empty_o)
      out_loads_o <= out_loads_o - 1'b1;
  end

  assign out_loads_full_o  = (out_loads_o == cnt_w_lp'(max_out_loads_p));
  assign out_loads_empty_o = (out_loads_o == '0);

  always @(posedge clk_i) begin
    if (!reset_i) begin
      if (int_wb_yumi_i) assert (int_wb_v_o);
      if (flt_wb_yumi_i) assert (flt_wb_v_o);
      if (int_wb_v_o) assert (!(head.is_byte && head.is_hex));
      if (load_issue_i && !enq) assert (!out_loads_full_o);
      if (enq && !load_issue_i) assert (!out_loads_empty_o);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_remote_load_resp.sv
`timescale 1ns/1ps
`default_nettype none
// tb_remote_load_resp: directed self-checking bench for remote_load_resp.
module tb_remote_load_resp;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        resp_v_i = 1'b0;
  logic        resp_ready_o;
  logic [31:0] resp_data_i = '0;
  logic [4:0]  resp_reg_id_i = '0;
  logic        resp_float_wb_i = 1'b0;
  logic        resp_icache_fetch_i = 1'b0;
  logic        resp_is_unsigned_i = 1'b0;
  logic        resp_is_byte_i = 1'b0;
  logic        resp_is_hex_i = 1'b0;
  logic [1:0]  resp_part_sel_i = '0;
  logic        load_issue_i = 1'b0;
  logic        int_wb_v_o;
  logic [4:0]  int_wb_rd_o;
  logic [31:0] int_wb_data_o;
  logic        int_wb_yumi_i = 1'b0;
  logic        flt_wb_v_o;
  logic [4:0]  flt_wb_rd_o;
  logic [31:0] flt_wb_data_o;
  logic        flt_wb_yumi_i = 1'b0;
  logic        icache_wb_v_o;
  logic [31:0] icache_wb_data_o;
  logic [5:0]  out_loads_o;
  logic        out_loads_full_o;
  logic        out_loads_empty_o;

  int checks = 0;
  int passed = 0;

  remote_load_resp dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .resp_v_i(resp_v_i), .resp_ready_o(resp_ready_o), .resp_data_i(resp_data_i),
    .resp_reg_id_i(resp_reg_id_i), .resp_float_wb_i(resp_float_wb_i),
    .resp_icache_fetch_i(resp_icache_fetch_i), .resp_is_unsigned_i(resp_is_unsigned_i),
    .resp_is_byte_i(resp_is_byte_i), .resp_is_hex_i(resp_is_hex_i),
    .resp_part_sel_i(resp_part_sel_i), .load_issue_i(load_issue_i),
    .int_wb_v_o(int_wb_v_o), .int_wb_rd_o(int_wb_rd_o), .int_wb_data_o(int_wb_data_o),
    .int_wb_yumi_i(int_wb_yumi_i),
    .flt_wb_v_o(flt_wb_v_o), .flt_wb_rd_o(flt_wb_rd_o), .flt_wb_data_o(flt_wb_data_o),
    .flt_wb_yumi_i(flt_wb_yumi_i),
    .icache_wb_v_o(icache_wb_v_o), .icache_wb_data_o(icache_wb_data_o),
    .out_loads_o(out_loads_o), .out_loads_full_o(out_loads_full_o),
    .out_loads_empty_o(out_loads_empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input int n);
    load_issue_i = 1'b1;
    repeat (n) tick();
    load_issue_i = 1'b0;
  endtask

  task automatic set_resp(input logic [31:0] d, input logic [4:0] rd, input logic fl,
                          input logic ic, input logic un, input logic by, input logic hx,
                          input logic [1:0] ps);
    resp_v_i = 1'b1; resp_data_i = d; resp_reg_id_i = rd; resp_float_wb_i = fl;
    resp_icache_fetch_i = ic; resp_is_unsigned_i = un; resp_is_byte_i = by;
    resp_is_hex_i = hx; resp_part_sel_i = ps;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (resp_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", resp_ready_o); else passed++;
    checks++; if ({int_wb_v_o, flt_wb_v_o, icache_wb_v_o} !== 3'b000) $display("FAIL reset_valids: got %b want 000", {int_wb_v_o, flt_wb_v_o, icache_wb_v_o}); else passed++;
    checks++; if (out_loads_o !== 6'd0) $display("FAIL reset_count: got %0d want 0", out_loads_o); else passed++;
    checks++; if (out_loads_empty_o !== 1'b1) $display("FAIL reset_empty: got %b want 1", out_loads_empty_o); else passed++;
    checks++; if (out_loads_full_o !== 1'b0) $display("FAIL reset_full: got %b want 0", out_loads_full_o); else passed++;
    tick(); tick();
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_counter;
    for (int i = 1; i <= 3; i++) begin
      load_issue_i = 1'b1;
      tick();
      checks++; if (out_loads_o !== 6'(i)) $display("FAIL count_up%0d: got %0d want %0d", i, out_loads_o, i); else passed++;
    end
    load_issue_i = 1'b0;
    set_resp(32'h0, 5'd0, 0, 0, 0, 0, 0, 2'd0);
    for (int i = 2; i >= 0; i--) begin
      tick();
      checks++; if (out_loads_o !== 6'(i)) $display("FAIL count_down%0d: got %0d want %0d", i, out_loads_o, i); else passed++;
    end
    resp_v_i = 1'b0;
    checks++; if (out_loads_empty_o !== 1'b1) $display("FAIL count_empty: got %b want 1", out_loads_empty_o); else passed++;
    tick();
    checks++; if (int_wb_v_o !== 1'b0) $display("FAIL count_rd0_silent: got %b want 0", int_wb_v_o); else passed++;
  endtask

  task automatic test_extract;
    logic [31:0] vd [7] = '{32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80011234,
                            32'h80011234, 32'h80011234, 32'hDEADBEEF};
    logic        vu [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        vb [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        vh [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0]  vp [7] = '{2'd3, 2'd1, 2'd2, 2'd2, 2'd0, 2'd3, 2'd0};
    logic [31:0] ve [7] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFF8001,
                            32'h00001234, 32'h00008001, 32'hDEADBEEF};
    issue(7);
    for (int i = 0; i < 7; i++) begin
      set_resp(vd[i], 5'(i + 1), 0, 0, vu[i], vb[i], vh[i], vp[i]);
      tick();
      resp_v_i = 1'b0;
      checks++; if (int_wb_v_o !== 1'b1) $display("FAIL ext%0d_v: got %b want 1", i, int_wb_v_o); else passed++;
      checks++; if (int_wb_data_o !== ve[i]) $display("FAIL ext%0d_data: got %h want %h", i, int_wb_data_o, ve[i]); else passed++;
      checks++; if (int_wb_rd_o !== 5'(i + 1)) $display("FAIL ext%0d_rd: got %0d want %0d", i, int_wb_rd_o, i + 1); else passed++;
      int_wb_yumi_i = 1'b1;
      tick();
      int_wb_yumi_i = 1'b0;
    end
    checks++; if (out_loads_o !== 6'd0) $display("FAIL ext_count: got %0d want 0", out_loads_o); else passed++;
  endtask

  task automatic test_back_to_back;
    issue(3);
    set_resp(32'h11111111, 5'd1, 0, 0, 0, 0, 0, 2'd0);
    checks++; if (resp_ready_o !== 1'b1) $display("FAIL b2b_ready0: got %b want 1", resp_ready_o); else passed++;
    tick();
    set_resp(32'h22222222, 5'd2, 0, 0, 0, 0, 0, 2'd0);
    checks++; if (resp_ready_o !== 1'b1) $display("FAIL b2b_ready1: got %b want 1", resp_ready_o); else passed++;
    tick();
    set_resp(32'h33333333, 5'd3, 0, 0, 0, 0, 0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (resp_ready_o !== 1'b0) $display("FAIL b2b_stall%0d_ready: got %b want 0", i, resp_ready_o); else passed++;
      checks++; if (int_wb_v_o !== 1'b1 || int_wb_rd_o !== 5'd1 || int_wb_data_o !== 32'h11111111)
        $display("FAIL b2b_stall%0d_hold: got v=%b rd=%0d data=%h want v=1 rd=1 data=11111111", i, int_wb_v_o, int_wb_rd_o, int_wb_data_o);
      else passed++;
      tick();
    end
    int_wb_yumi_i = 1'b1;
    tick();
    checks++; if (resp_ready_o !== 1'b1) $display("FAIL b2b_ready_after: got %b want 1", resp_ready_o); else passed++;
    checks++; if (int_wb_rd_o !== 5'd2 || int_wb_data_o !== 32'h22222222) $display("FAIL b2b_second: got rd=%0d data=%h want rd=2 data=22222222", int_wb_rd_o, int_wb_data_o); else passed++;
    tick();
    resp_v_i = 1'b0;
    checks++; if (int_wb_v_o !== 1'b1 || int_wb_rd_o !== 5'd3 || int_wb_data_o !== 32'h33333333) $display("FAIL b2b_third: got v=%b rd=%0d data=%h want v=1 rd=3 data=33333333", int_wb_v_o, int_wb_rd_o, int_wb_data_o); else passed++;
    tick();
    int_wb_yumi_i = 1'b0;
    checks++; if (int_wb_v_o !== 1'b0) $display("FAIL b2b_drained: got %b want 0", int_wb_v_o); else passed++;
    checks++; if (out_loads_o !== 6'd0) $display("FAIL b2b_count: got %0d want 0", out_loads_o); else passed++;
  endtask

  task automatic test_mixed;
    issue(3);
    set_resp(32'h00000013, 5'd0, 0, 1, 0, 0, 0, 2'd0);
    tick();
    set_resp(32'h3F800000, 5'd4, 1, 0, 0, 0, 0, 2'd0);
    checks++; if (icache_wb_v_o !== 1'b1 || icache_wb_data_o !== 32'h00000013) $display("FAIL mix_icache: got v=%b data=%h want v=1 data=00000013", icache_wb_v_o, icache_wb_data_o); else passed++;
    checks++; if ({flt_wb_v_o, int_wb_v_o} !== 2'b00) $display("FAIL mix_icache_only: got %b want 00", {flt_wb_v_o, int_wb_v_o}); else passed++;
    tick();
    set_resp(32'hAAAA5555, 5'd0, 0, 0, 0, 0, 0, 2'd0);
    checks++; if (icache_wb_v_o !== 1'b0) $display("FAIL mix_icache_pulse: got %b want 0", icache_wb_v_o); else passed++;
    checks++; if (flt_wb_v_o !== 1'b1 || flt_wb_rd_o !== 5'd4 || flt_wb_data_o !== 32'h3F800000) $display("FAIL mix_flt: got v=%b rd=%0d data=%h want v=1 rd=4 data=3f800000", flt_wb_v_o, flt_wb_rd_o, flt_wb_data_o); else passed++;
    checks++; if (int_wb_v_o !== 1'b0) $display("FAIL mix_flt_only: got %b want 0", int_wb_v_o); else passed++;
    tick();
    resp_v_i = 1'b0;
    checks++; if (flt_wb_v_o !== 1'b1) $display("FAIL mix_flt_hold: got %b want 1", flt_wb_v_o); else passed++;
    flt_wb_yumi_i = 1'b1;
    tick();
    flt_wb_yumi_i = 1'b0;
    checks++; if ({icache_wb_v_o, flt_wb_v_o, int_wb_v_o} !== 3'b000) $display("FAIL mix_rd0_silent: got %b want 000", {icache_wb_v_o, flt_wb_v_o, int_wb_v_o}); else passed++;
    tick();
    checks++; if (out_loads_o !== 6'd0) $display("FAIL mix_count: got %0d want 0", out_loads_o); else passed++;
    checks++; if (resp_ready_o !== 1'b1 || {icache_wb_v_o, flt_wb_v_o, int_wb_v_o} !== 3'b000) $display("FAIL mix_idle: got ready=%b v=%b want ready=1 v=000", resp_ready_o, {icache_wb_v_o, flt_wb_v_o, int_wb_v_o}); else passed++;
  endtask

  task automatic test_count_reset;
    issue(5);
    checks++; if (out_loads_o !== 6'd5) $display("FAIL cr_count5: got %0d want 5", out_loads_o); else passed++;
    set_resp(32'h0, 5'd0, 0, 0, 0, 0, 0, 2'd0);
    load_issue_i = 1'b1;
    tick();
    load_issue_i = 1'b0;
    resp_v_i = 1'b0;
    checks++; if (out_loads_o !== 6'd5) $display("FAIL cr_both: got %0d want 5", out_loads_o); else passed++;
    tick();
    issue(2);
    set_resp(32'hCAFE0001, 5'd9, 0, 0, 0, 0, 0, 2'd0);
    tick();
    set_resp(32'hCAFE0002, 5'd10, 0, 0, 0, 0, 0, 2'd0);
    tick();
    resp_v_i = 1'b0;
    checks++; if (resp_ready_o !== 1'b0 || int_wb_v_o !== 1'b1) $display("FAIL cr_stalled: got ready=%b v=%b want ready=0 v=1", resp_ready_o, int_wb_v_o); else passed++;
    checks++; if (out_loads_o !== 6'd5) $display("FAIL cr_count_pre: got %0d want 5", out_loads_o); else passed++;
    reset_i = 1'b1;
    #1;
    checks++; if (int_wb_v_o !== 1'b0 || resp_ready_o !== 1'b1) $display("FAIL cr_async: got v=%b ready=%b want v=0 ready=1", int_wb_v_o, resp_ready_o); else passed++;
    checks++; if (out_loads_o !== 6'd0 || out_loads_empty_o !== 1'b1) $display("FAIL cr_async_count: got %0d empty=%b want 0 empty=1", out_loads_o, out_loads_empty_o); else passed++;
    tick();
    reset_i = 1'b0;
    tick();
    checks++; if ({icache_wb_v_o, flt_wb_v_o, int_wb_v_o} !== 3'b000) $display("FAIL cr_discarded: got %b want 000", {icache_wb_v_o, flt_wb_v_o, int_wb_v_o}); else passed++;
  endtask

  initial begin
    test_reset();
    test_counter();
    test_extract();
    test_back_to_back();
    test_mixed();
    test_count_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
